// File: rtl/logic_column_pkg.sv
// Shared types and sizing helpers for the logic column and its configuration loader.
package logic_column_pkg;

  typedef enum logic [1:0] {
    UNCONFIGURED = 2'd0,
    LOAD         = 2'd1,
    ACTIVE       = 2'd2
  } cfg_state_t;

  // Number of configuration beats needed to cover every tile's config bits.
  function automatic int unsigned cfg_words(input int unsigned tiles,
                                            input int unsigned tile_bits,
                                            input int unsigned word_bits);
    return (tiles * tile_bits + word_bits - 1) / word_bits;
  endfunction

endpackage

// File: rtl/logic_column_cfg_loader.sv
// Word-serial configuration loader: ready/valid intake, shift register, load FSM, tile reset.
// Optional readback of the outgoing bitstream with LOGIC_COLUMN_CFG_READBACK_EN.
module logic_column_cfg_loader
  import logic_column_pkg::*;
#(
  parameter int unsigned TILE_COUNT        = 3,
  parameter int unsigned TILE_CONFIG_WIDTH = 194,
  parameter int unsigned CFG_WORD_WIDTH    = 32
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    cfg_start,
  input  logic                                    cfg_valid,
  input  logic [CFG_WORD_WIDTH-1:0]               cfg_data,
  output logic                                    cfg_ready,
  output logic                                    cfg_busy,
  output logic                                    cfg_done,
  output logic [CFG_WORD_WIDTH-1:0]               cfg_rb_data,
  output logic                                    tile_nreset,
  output logic [TILE_COUNT*TILE_CONFIG_WIDTH-1:0] tile_cfg
);

  localparam int unsigned CFG_BITS  = TILE_COUNT * TILE_CONFIG_WIDTH;
  localparam int unsigned CFG_WORDS = cfg_words(TILE_COUNT, TILE_CONFIG_WIDTH, CFG_WORD_WIDTH);
  localparam int unsigned SR_W      = CFG_WORDS * CFG_WORD_WIDTH;
  localparam int unsigned CNT_W     = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
  localparam int unsigned LAST      = CFG_WORDS - 1;

  cfg_state_t       state;
  logic [SR_W-1:0]  cfg_sr;
  logic [SR_W-1:0]  sr_shift_c;
  logic [CNT_W-1:0] cnt;

  if (CFG_WORDS > 1) begin : g_shift
    assign sr_shift_c = {cfg_data, cfg_sr[SR_W-1:CFG_WORD_WIDTH]};
  end else begin : g_single
    assign sr_shift_c = cfg_data;
  end

  assign tile_cfg = cfg_sr[CFG_BITS-1:0];

`ifdef LOGIC_COLUMN_CFG_READBACK_EN
  logic [CFG_WORD_WIDTH-1:0] rb_q;
  assign cfg_rb_data = rb_q;
`else
  assign cfg_rb_data = '0;
`endif

  // cfg_start wins over a beat presented in the same cycle; that beat is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= UNCONFIGURED;
      cfg_sr      <= '0;
      cnt         <= '0;
      cfg_ready   <= 1'b0;
      cfg_busy    <= 1'b0;
      cfg_done    <= 1'b0;
      tile_nreset <= 1'b0;
`ifdef LOGIC_COLUMN_CFG_READBACK_EN
      rb_q        <= '0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (cfg_start) begin
            cnt <= '0;
          end else if (cfg_valid && cfg_ready) begin
            cfg_sr <= sr_shift_c;
`ifdef LOGIC_COLUMN_CFG_READBACK_EN
            rb_q   <= cfg_sr[CFG_WORD_WIDTH-1:0];
`endif
            if (cnt == CNT_W'(LAST)) begin
              state       <= ACTIVE;
              cnt         <= '0;
              cfg_ready   <= 1'b0;
              cfg_busy    <= 1'b0;
              cfg_done    <= 1'b1;
              tile_nreset <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (cfg_start) begin
            state       <= LOAD;
            cnt         <= '0;
            cfg_ready   <= 1'b1;
            cfg_busy    <= 1'b1;
            cfg_done    <= 1'b0;
            tile_nreset <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/logic_tile.sv
// Behavioural LogicTile: registered pass-through of each side, keyed by its configuration.
// Requires CONFIG_WIDTH >= 4*IO_WIDTH; bits above the four side keys fold into one parity bit.
module logic_tile #(
  parameter int unsigned IO_WIDTH     = 6,
  parameter int unsigned CONFIG_WIDTH = 194
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic [CONFIG_WIDTH-1:0] cfg,
  input  logic [IO_WIDTH-1:0]     north_in,
  input  logic [IO_WIDTH-1:0]     south_in,
  input  logic [IO_WIDTH-1:0]     east_in,
  input  logic [IO_WIDTH-1:0]     west_in,
  output logic [IO_WIDTH-1:0]     north_out,
  output logic [IO_WIDTH-1:0]     south_out,
  output logic [IO_WIDTH-1:0]     east_out,
  output logic [IO_WIDTH-1:0]     west_out
);

  localparam int unsigned KEY_BITS = 4 * IO_WIDTH;

  logic [IO_WIDTH-1:0] mix_c;

  if (CONFIG_WIDTH > KEY_BITS) begin : g_mix
    assign mix_c = {IO_WIDTH{^cfg[CONFIG_WIDTH-1:KEY_BITS]}};
  end else begin : g_no_mix
    assign mix_c = '0;
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      north_out <= '0;
      south_out <= '0;
      east_out  <= '0;
      west_out  <= '0;
    end else begin
      north_out <= south_in ^ cfg[0*IO_WIDTH +: IO_WIDTH] ^ mix_c;
      south_out <= north_in ^ cfg[1*IO_WIDTH +: IO_WIDTH] ^ mix_c;
      east_out  <= west_in  ^ cfg[2*IO_WIDTH +: IO_WIDTH] ^ mix_c;
      west_out  <= east_in  ^ cfg[3*IO_WIDTH +: IO_WIDTH] ^ mix_c;
    end
  end

endmodule

// File: rtl/logic_column_n.sv
// Logic column: TILE_COUNT stacked tiles with abutting north/south links and a serial config loader.
// Build option LOGIC_COLUMN_CFG_READBACK_EN enables bitstream readback on cfg_rb_data.
module logic_column_n
  import logic_column_pkg::*;
#(
  parameter int unsigned TILE_COUNT        = 3,
  parameter int unsigned IO_WIDTH          = 6,
  parameter int unsigned TILE_CONFIG_WIDTH = 194,
  parameter int unsigned CFG_WORD_WIDTH    = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [IO_WIDTH-1:0]            data_north_in,
  output logic [IO_WIDTH-1:0]            data_north_out,
  input  logic [IO_WIDTH-1:0]            data_south_in,
  output logic [IO_WIDTH-1:0]            data_south_out,
  input  logic [TILE_COUNT*IO_WIDTH-1:0] data_east_in,
  output logic [TILE_COUNT*IO_WIDTH-1:0] data_east_out,
  input  logic [TILE_COUNT*IO_WIDTH-1:0] data_west_in,
  output logic [TILE_COUNT*IO_WIDTH-1:0] data_west_out,
  input  logic                           cfg_start,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [CFG_WORD_WIDTH-1:0]      cfg_data,
  output logic                           cfg_busy,
  output logic                           cfg_done,
  output logic [CFG_WORD_WIDTH-1:0]      cfg_rb_data
);

  localparam int unsigned CFG_BITS = TILE_COUNT * TILE_CONFIG_WIDTH;

  logic                tile_nreset;
  logic [CFG_BITS-1:0] tile_cfg;
  logic [IO_WIDTH-1:0] north_link [TILE_COUNT];
  logic [IO_WIDTH-1:0] south_link [TILE_COUNT];

  logic_column_cfg_loader #(
    .TILE_COUNT        (TILE_COUNT),
    .TILE_CONFIG_WIDTH (TILE_CONFIG_WIDTH),
    .CFG_WORD_WIDTH    (CFG_WORD_WIDTH)
  ) u_loader (
    .clock       (clock),
    .reset       (reset),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_ready   (cfg_ready),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_rb_data (cfg_rb_data),
    .tile_nreset (tile_nreset),
    .tile_cfg    (tile_cfg)
  );

  // Tile 0 sits at the south edge; tile TILE_COUNT-1 at the north edge.
  for (genvar k = 0; k < TILE_COUNT; k++) begin : g_tile
    logic [IO_WIDTH-1:0] south_src;
    logic [IO_WIDTH-1:0] north_src;

    if (k == 0) begin : g_bot
      assign south_src = data_south_in;
    end else begin : g_mid_s
      assign south_src = north_link[k-1];
    end

    if (k == TILE_COUNT - 1) begin : g_top
      assign north_src = data_north_in;
    end else begin : g_mid_n
      assign north_src = south_link[k+1];
    end

    logic_tile #(
      .IO_WIDTH     (IO_WIDTH),
      .CONFIG_WIDTH (TILE_CONFIG_WIDTH)
    ) u_tile (
      .clock     (clock),
      .nreset    (tile_nreset),
      .cfg       (tile_cfg[k*TILE_CONFIG_WIDTH +: TILE_CONFIG_WIDTH]),
      .north_in  (north_src),
      .south_in  (south_src),
      .east_in   (data_east_in[k*IO_WIDTH +: IO_WIDTH]),
      .west_in   (data_west_in[k*IO_WIDTH +: IO_WIDTH]),
      .north_out (north_link[k]),
      .south_out (south_link[k]),
      .east_out  (data_east_out[k*IO_WIDTH +: IO_WIDTH]),
      .west_out  (data_west_out[k*IO_WIDTH +: IO_WIDTH])
    );
  end

  assign data_north_out = north_link[TILE_COUNT-1];
  assign data_south_out = south_link[0];

endmodule

// File: doc/logic_column_n.md
# logic_column_n

Parametrised logic column: a vertical stack of `TILE_COUNT` LogicTile instances with abutting north/south links and per-tile east/west buses. It replaces the flat, externally-held configuration bus with an internal word-serial configuration loader: ready/valid handshake, shift register, load FSM. Tiles are held in reset until a complete bitstream has been loaded. It sits between the fabric top and the tiles, one instance per column.

## Interface
Parameters:
- `TILE_COUNT`, 3: tiles in the column, ≥1.
- `IO_WIDTH`, 6: data wires per tile per side.
- `TILE_CONFIG_WIDTH`, 194: config bits per tile.
- `CFG_WORD_WIDTH`, 32: configuration beat width.
- Derived: `CFG_BITS = TILE_COUNT*TILE_CONFIG_WIDTH`; `CFG_WORDS = ceil(CFG_BITS/CFG_WORD_WIDTH)`.

Ports:
- `clock`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `data_north_in` / `data_north_out`, in/out, `IO_WIDTH`: top tile north side.
- `data_south_in` / `data_south_out`, in/out, `IO_WIDTH`: tile 0 south side.
- `data_east_in` / `data_east_out`, in/out, `TILE_COUNT*IO_WIDTH`: tile k on bits `[k*IO_WIDTH +: IO_WIDTH]`.
- `data_west_in` / `data_west_out`, in/out, `TILE_COUNT*IO_WIDTH`: same slicing as east.
- `cfg_start`, in, 1: single-cycle request to begin or restart a load.
- `cfg_valid`, in, 1: `cfg_data` is valid.
- `cfg_ready`, out, 1: loader accepts a beat. Registered.
- `cfg_data`, in, `CFG_WORD_WIDTH`: configuration beat.
- `cfg_busy`, out, 1: high in state LOAD.
- `cfg_done`, out, 1: high in state ACTIVE.
- `cfg_rb_data`, out, `CFG_WORD_WIDTH`: readback word (see Configuration).

## Operation
- Tile chaining: tile k north_in is tile k+1 south_out. Tile k south_in is tile k-1 north_out. Column edges connect to the top and bottom tiles.
- Shift register `cfg_sr` is `CFG_WORDS*CFG_WORD_WIDTH` bits. On each accepted beat: `cfg_sr <= {cfg_data, cfg_sr[MSB:CFG_WORD_WIDTH]}`.
- After `CFG_WORDS` beats, the first beat sits at `[CFG_WORD_WIDTH-1:0]`. Tile k config is `cfg_sr[k*TILE_CONFIG_WIDTH +: TILE_CONFIG_WIDTH]`. Padding bits at the top of the last beat are ignored.
- Beat accepted when `cfg_valid && cfg_ready`.
- FSM states: UNCONFIGURED (reset state), LOAD, ACTIVE.
  - UNCONFIGURED or ACTIVE + `cfg_start` → LOAD. Word counter cleared to 0.
  - LOAD: accepted beat increments the counter. Accepted beat with counter == `CFG_WORDS-1` → ACTIVE.
  - LOAD + `cfg_start` → stays in LOAD with counter = 0. A beat accepted in the same cycle is consumed and discarded (not shifted). `cfg_start` has priority.
  - ACTIVE holds until `cfg_start` or `reset`.
- Tile nreset is a registered signal: `tile_nreset <= (next_state == ACTIVE)`. Tiles run only in ACTIVE and are held in reset from the cycle after leaving ACTIVE.
- Reset values: state UNCONFIGURED, `cfg_sr` all 0, counter 0, `cfg_ready` 0, `cfg_busy` 0, `cfg_done` 0, `cfg_rb_data` 0, `tile_nreset` 0. Data outputs are whatever tiles held in reset drive.
- Reset asserted mid-LOAD aborts the load. Partial contents are cleared.
- Counter width is `$clog2(CFG_WORDS)`, minimum 1 bit. It never exceeds `CFG_WORDS-1`.

## Timing
- `cfg_start` at cycle t → `cfg_ready`, `cfg_busy` high at t+1.
- Throughput: one beat per cycle. `cfg_valid` may toggle freely. No beat is lost while `cfg_ready` is high, except the documented start collision.
- Last beat accepted at cycle t → at t+1: `cfg_ready` 0, `cfg_busy` 0, `cfg_done` 1, `tile_nreset` 1.
- Minimum load is `CFG_WORDS` cycles plus 1 cycle for the start.
- `cfg_start` in ACTIVE at t → `cfg_done` 0 and tiles in reset at t+1.

## Configuration
- Macro: `LOGIC_COLUMN_CFG_READBACK_EN`.
- Defined: on each accepted, non-discarded beat, `cfg_rb_data <= cfg_sr[CFG_WORD_WIDTH-1:0]` (the word being shifted out). Loading a new bitstream therefore streams out the previous one, in order.
- Undefined: `cfg_rb_data` is tied to 0. The port is always present.

## Structure
- Package `logic_column_pkg`:
  - state enum `cfg_state_t` {UNCONFIGURED, LOAD, ACTIVE};
  - function `cfg_words(tiles, tile_bits, word_bits)`.
- Sub-module `logic_column_cfg_loader`: FSM, counter, shift register, readback, `tile_nreset`.
- The top level holds the generate loop of LogicTile instances and the bus slicing.

## Test plan
Defaults (`CFG_WORDS` = 19):
- Reset, then idle 10 cycles → `cfg_ready`=0, `cfg_done`=0, `cfg_busy`=0, `tile_nreset`=0.
- `cfg_start`, then 19 back-to-back beats 0x00000000..0x00000012 → `cfg_done`=1 one cycle after beat 19. Tile 0 config bits [31:0]=0x0, tile 2 config = `cfg_sr[581:388]`, padding bits [607:582] ignored.
- Same load with `cfg_valid` toggling every other cycle → identical final `cfg_sr`, done after 38 data cycles.
- `cfg_start` with `cfg_valid` high at beat 7 → beat dropped, counter 0, 19 further beats needed for done.
- `reset` at beat 10 → all state cleared, next full load completes normally.
- Readback enabled: load pattern A, then pattern B → `cfg_rb_data` emits A words 0..18 in order during the B load.
